// File: rtl/road_sensor_pkg.sv
// Shared definitions for the multi-road vehicle-count averager:
// road indices, FSM state type and the default window preload value.
package road_sensor_pkg;

   localparam int NORTH = 0;
   localparam int EAST  = 1;
   localparam int SOUTH = 2;
   localparam int WEST  = 3;

   localparam int DEFAULT_INIT_VAL = 20;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/road_sensor_avg_channel.sv
// One road's moving-average window: ring buffer, write pointer, running sum and
// average register. A peak-sample register is added when ROAD_SENSOR_PEAK_EN is defined.
module avg_channel
   import road_sensor_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int WIN_LOG2 = 6,
   parameter int INIT_VAL = DEFAULT_INIT_VAL
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init_we,
   input  logic [WIN_LOG2-1:0] init_idx,
   input  logic                sample_we,
   input  logic [DATA_W-1:0]   sample_data,
   output logic [DATA_W-1:0]   avg
`ifdef ROAD_SENSOR_PEAK_EN
   ,
   output logic [DATA_W-1:0]   peak
`endif
);

   localparam int DEPTH = 2 ** WIN_LOG2;
   localparam int SUM_W = DATA_W + WIN_LOG2;
   localparam logic [DATA_W-1:0] INIT_DATA = DATA_W'(INIT_VAL);
   localparam logic [SUM_W-1:0]  INIT_SUM  = SUM_W'(INIT_VAL) << WIN_LOG2;

   logic [DATA_W-1:0]   buf_mem [DEPTH];
   logic [WIN_LOG2-1:0] ptr_q, ptr_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [DATA_W-1:0]   avg_q, avg_d;
   logic                wr_en;
   logic [WIN_LOG2-1:0] wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [DATA_W-1:0]   oldest;
   logic [SUM_W-1:0]    new_sum;

   // Modular arithmetic in sum width: the evicted sample is always part of the sum
   assign oldest  = buf_mem[ptr_q];
   assign new_sum = sum_q + SUM_W'(sample_data) - SUM_W'(oldest);

   always_comb begin
      ptr_d   = ptr_q;
      sum_d   = sum_q;
      avg_d   = avg_q;
      wr_en   = 1'b0;
      wr_addr = ptr_q;
      wr_data = sample_data;
      if (init_we) begin
         wr_en   = 1'b1;
         wr_addr = init_idx;
         wr_data = INIT_DATA;
      end else if (sample_we) begin
         wr_en = 1'b1;
         ptr_d = ptr_q + WIN_LOG2'(1);
         sum_d = new_sum;
         avg_d = new_sum[SUM_W-1:WIN_LOG2];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q <= '0;
         sum_q <= INIT_SUM;
         avg_q <= INIT_DATA;
      end else begin
         ptr_q <= ptr_d;
         sum_q <= sum_d;
         avg_q <= avg_d;
      end
   end

   // No reset on the storage itself; the INIT sweep rewrites every slot
   always_ff @(posedge clk) begin
      if (reset && wr_en) begin
         buf_mem[wr_addr] <= wr_data;
      end
   end

   assign avg = avg_q;

`ifdef ROAD_SENSOR_PEAK_EN
   logic [DATA_W-1:0] peak_q, peak_d;

   always_comb begin
      peak_d = peak_q;
      if (sample_we && (sample_data > peak_q)) begin
         peak_d = sample_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         peak_q <= INIT_DATA;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign peak = peak_q;
`endif

endmodule

// File: rtl/road_sensor_avg.sv
// Multi-road moving-average block: INIT/RUN FSM, window preload counter, handshake,
// road decode and update pulse. Optional per-road peak output under ROAD_SENSOR_PEAK_EN.
module road_sensor_avg
   import road_sensor_pkg::*;
#(
   parameter int NUM_ROADS = 4,
   parameter int DATA_W    = 8,
   parameter int WIN_LOG2  = 6,
   parameter int INIT_VAL  = DEFAULT_INIT_VAL,
   parameter int ROAD_W    = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [ROAD_W-1:0]           in_road,
   input  logic [DATA_W-1:0]           in_data,
   output logic [NUM_ROADS*DATA_W-1:0] avg_flat,
   output logic                        avg_valid,
   output logic [ROAD_W-1:0]           avg_road,
`ifdef ROAD_SENSOR_PEAK_EN
   output logic [NUM_ROADS*DATA_W-1:0] peak_flat,
`endif
   output logic                        init_done
);

   state_t              state_q, state_d;
   logic [WIN_LOG2-1:0] init_idx_q, init_idx_d;
   logic                in_ready_q, in_ready_d;
   logic                init_done_q, init_done_d;
   logic                avg_valid_q, avg_valid_d;
   logic [ROAD_W-1:0]   avg_road_q, avg_road_d;
   logic                accept;
   logic                road_ok;
   logic                init_we;

   assign accept  = in_valid & in_ready_q;
   assign road_ok = (32'(in_road) < NUM_ROADS);
   assign init_we = (state_q == INIT);

   // in_ready/init_done rise on the same edge that leaves INIT, so they are never early
   always_comb begin
      state_d     = state_q;
      init_idx_d  = init_idx_q;
      in_ready_d  = in_ready_q;
      init_done_d = init_done_q;
      avg_valid_d = 1'b0;
      avg_road_d  = avg_road_q;
      case (state_q)
         INIT: begin
            init_idx_d = init_idx_q + WIN_LOG2'(1);
            if (init_idx_q == '1) begin
               state_d     = RUN;
               in_ready_d  = 1'b1;
               init_done_d = 1'b1;
            end
         end
         RUN: begin
            in_ready_d  = 1'b1;
            init_done_d = 1'b1;
            if (accept && road_ok) begin
               avg_valid_d = 1'b1;
               avg_road_d  = in_road;
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= INIT;
         init_idx_q  <= '0;
         in_ready_q  <= 1'b0;
         init_done_q <= 1'b0;
         avg_valid_q <= 1'b0;
         avg_road_q  <= '0;
      end else begin
         state_q     <= state_d;
         init_idx_q  <= init_idx_d;
         in_ready_q  <= in_ready_d;
         init_done_q <= init_done_d;
         avg_valid_q <= avg_valid_d;
         avg_road_q  <= avg_road_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign init_done = init_done_q;
   assign avg_valid = avg_valid_q;
   assign avg_road  = avg_road_q;

   for (genvar r = 0; r < NUM_ROADS; r++) begin : g_road
      logic sample_we;

      assign sample_we = accept && road_ok && (in_road == ROAD_W'(r));

      avg_channel #(
         .DATA_W   (DATA_W),
         .WIN_LOG2 (WIN_LOG2),
         .INIT_VAL (INIT_VAL)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .init_we     (init_we),
         .init_idx    (init_idx_q),
         .sample_we   (sample_we),
         .sample_data (in_data),
         .avg         (avg_flat[r*DATA_W +: DATA_W])
`ifdef ROAD_SENSOR_PEAK_EN
         ,
         .peak        (peak_flat[r*DATA_W +: DATA_W])
`endif
      );
   end

endmodule

// File: tb/tb_road_sensor_avg.sv
// Scoreboard bench for road_sensor_avg: a window-queue model predicts each update,
// a negedge monitor compares. Also covers ROAD_SENSOR_PEAK_EN when defined.
module tb_road_sensor_avg;
   import road_sensor_pkg::*;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int WL = 6;
   localparam int DEPTH = 64;
   localparam int IV = DEFAULT_INIT_VAL;

   typedef struct {
      int          cyc;
      int          road;
      logic [31:0] avg;
      logic [31:0] peak;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_road = '0;
   logic [7:0]  in_data = '0;
   logic [31:0] avg_flat;
   logic        avg_valid;
   logic [1:0]  avg_road;
   logic        init_done;
   logic [31:0] peak_flat;

   logic        v3 = 1'b0;
   logic        ready3;
   logic [1:0]  rd3 = '0;
   logic [7:0]  d3 = '0;
   logic [23:0] flat3;
   logic        valid3;
   logic [1:0]  road3o;
   logic        done3;
   logic [23:0] peak3;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   model_run = 0;
   int   win [NR][$];
   int   peak_m [NR];
   exp_t sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   road_sensor_avg #(.NUM_ROADS(NR), .DATA_W(DW), .WIN_LOG2(WL), .INIT_VAL(IV)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_road   (in_road),
      .in_data   (in_data),
      .avg_flat  (avg_flat),
      .avg_valid (avg_valid),
      .avg_road  (avg_road),
`ifdef ROAD_SENSOR_PEAK_EN
      .peak_flat (peak_flat),
`endif
      .init_done (init_done)
   );

   road_sensor_avg #(.NUM_ROADS(3), .DATA_W(DW), .WIN_LOG2(WL), .INIT_VAL(IV)) dut3 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (v3),
      .in_ready  (ready3),
      .in_road   (rd3),
      .in_data   (d3),
      .avg_flat  (flat3),
      .avg_valid (valid3),
      .avg_road  (road3o),
`ifdef ROAD_SENSOR_PEAK_EN
      .peak_flat (peak3),
`endif
      .init_done (done3)
   );

`ifndef ROAD_SENSOR_PEAK_EN
   assign peak_flat = '0;
   assign peak3 = '0;
`endif

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] modelAvgFlat();
      logic [31:0] f;
      f = '0;
      for (int r = 0; r < NR; r++) begin
         int s;
         s = 0;
         foreach (win[r][k]) s += win[r][k];
         f[r*8 +: 8] = 8'(s / DEPTH);
      end
      return f;
   endfunction

   function automatic logic [31:0] modelPeakFlat();
      logic [31:0] f;
      f = '0;
      for (int r = 0; r < NR; r++) f[r*8 +: 8] = 8'(peak_m[r]);
      return f;
   endfunction

   task automatic modelReset();
      for (int r = 0; r < NR; r++) begin
         win[r].delete();
         for (int k = 0; k < DEPTH; k++) win[r].push_back(IV);
         peak_m[r] = IV;
      end
      sb.delete();
      model_run = 0;
   endtask

   task automatic modelAccept(input int road, input int data);
      exp_t e;
      win[road].push_back(data);
      void'(win[road].pop_front());
      if (data > peak_m[road]) peak_m[road] = data;
      e.cyc  = cyc + 1;
      e.road = road;
      e.avg  = modelAvgFlat();
      e.peak = modelPeakFlat();
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input int road, input int data);
      in_valid = 1'b1;
      in_road  = 2'(road);
      in_data  = 8'(data);
      checkOutput("in_ready_run", 64'(in_ready), 64'(model_run));
      if (model_run) modelAccept(road, data);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic waitInit();
      int n;
      bit early_ready;
      n = 0;
      early_ready = 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         n = i;
         if (init_done === 1'b1) break;
         if (in_ready !== 1'b0) early_ready = 1;
      end
      checkOutput("init_cycles", 64'(n), 64'(DEPTH));
      checkOutput("in_ready_during_init", 64'(early_ready), 64'd0);
      checkOutput("lanes_after_init", 64'(avg_flat), 64'({4{8'd20}}));
`ifdef ROAD_SENSOR_PEAK_EN
      checkOutput("peaks_after_init", 64'(peak_flat), 64'({4{8'd20}}));
`endif
      model_run = 1;
   endtask

   // Monitor: every avg_valid pulse must match the oldest prediction, on its cycle
   always @(negedge clk) begin
      exp_t e;
      if (avg_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_avg_valid: got road %0d, none expected (t=%0t)", avg_road, $time);
         end else begin
            e = sb.pop_front();
            checkOutput("avg_cycle", 64'(cyc), 64'(e.cyc));
            checkOutput("avg_road", 64'(avg_road), 64'(e.road));
            checkOutput("avg_flat", 64'(avg_flat), 64'(e.avg));
`ifdef ROAD_SENSOR_PEAK_EN
            checkOutput("peak_flat", 64'(peak_flat), 64'(e.peak));
`endif
         end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL missing_avg_valid: got none, expected road %0d at cycle %0d", e.road, e.cyc);
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      modelReset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_avg_valid", 64'(avg_valid), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst_init_done", 64'(init_done), 64'd0);
      checkOutput("rst_avg_road", 64'(avg_road), 64'd0);
      checkOutput("rst_lanes", 64'(avg_flat), 64'({4{8'd20}}));
      reset = 1'b1;
      waitInit();

      // Out-of-range road on the three-road instance
      checkOutput("oor_ready", 64'(ready3), 64'd1);
      v3 = 1'b1; rd3 = 2'd3; d3 = 8'd200;
      @(posedge clk); #1;
      v3 = 1'b0;
      checkOutput("oor_valid", 64'(valid3), 64'd0);
      checkOutput("oor_lanes", 64'(flat3), 64'({3{8'd20}}));
      v3 = 1'b1; rd3 = 2'd2; d3 = 8'd84;
      @(posedge clk); #1;
      v3 = 1'b0;
      checkOutput("r3_valid", 64'(valid3), 64'd1);
      checkOutput("r3_road", 64'(road3o), 64'd2);
      checkOutput("r3_lanes", 64'(flat3), 64'({8'd21, 8'd20, 8'd20}));
      v3 = 1'b1; rd3 = 2'd3; d3 = 8'd200;
      @(posedge clk); #1;
      v3 = 1'b0;
      checkOutput("oor2_valid", 64'(valid3), 64'd0);
      checkOutput("oor2_lanes", 64'(flat3), 64'({8'd21, 8'd20, 8'd20}));

      applyStimulus(NORTH, 84);
      idle(1);
      checkOutput("single_lanes", 64'(avg_flat), 64'({8'd20, 8'd20, 8'd20, 8'd21}));

      for (int i = 0; i < 63; i++) applyStimulus(NORTH, 84);
      idle(1);
      checkOutput("fill_lane0", 64'(avg_flat[7:0]), 64'd84);
      applyStimulus(NORTH, 0);
      idle(1);
      checkOutput("wrap_lane0", 64'(avg_flat[7:0]), 64'd82);

      for (int i = 0; i < 64; i++) begin
         applyStimulus(EAST, 255);
         applyStimulus(WEST, 0);
      end
      idle(1);
      checkOutput("interleave_lane1", 64'(avg_flat[15:8]), 64'd255);
      checkOutput("interleave_lane3", 64'(avg_flat[31:24]), 64'd0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else applyStimulus($urandom_range(0, 3), $urandom_range(0, 255));
      end
      idle(2);
      checkOutput("sb_empty_random", 64'(sb.size()), 64'd0);

      for (int i = 0; i < 10; i++) applyStimulus(SOUTH, $urandom_range(100, 255));
      // An extra request rides into the reset edge and must leave no trace
      reset = 1'b0;
      in_valid = 1'b1; in_road = 2'(SOUTH); in_data = 8'd250;
      @(posedge clk); #1;
      in_valid = 1'b0;
      modelReset();
      checkOutput("midrst_avg_valid", 64'(avg_valid), 64'd0);
      checkOutput("midrst_lanes", 64'(avg_flat), 64'({4{8'd20}}));
      checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
`ifdef ROAD_SENSOR_PEAK_EN
      checkOutput("midrst_peaks", 64'(peak_flat), 64'({4{8'd20}}));
`endif
      reset = 1'b1;
      waitInit();
      applyStimulus(SOUTH, 148);
      idle(2);
      checkOutput("post_rst_lane2", 64'(avg_flat[23:16]), 64'd22);
      checkOutput("sb_empty_end", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/road_sensor_avg.md
Name: road_sensor_avg

Overview:
- Clocked, parametrised multi-road successor to the single-road vehicle-count averager.
- Keeps one moving-average window per road: a ring buffer of the last 2**WIN_LOG2 samples plus a running sum (add newest, subtract oldest).
- Sits between the per-road count sources and the signal controller's road-priority logic.
- Accepts samples over a valid/ready handshake and publishes every road's average in parallel.

Parameters:
- NUM_ROADS, 4, number of independent road channels (road index 0 = north).
- DATA_W, 8, width of a vehicle-count sample and of each average.
- WIN_LOG2, 6, window depth is 2**WIN_LOG2 samples per road.
- INIT_VAL, 20, preload value written to every window slot after reset.
- ROAD_W, $clog2(NUM_ROADS) (minimum 1), width of road index ports.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  sample request.
- in_ready  output  1  block can accept a sample this cycle.
- in_road  input  ROAD_W  road the sample belongs to.
- in_data  input  DATA_W  vehicle count sample.
- avg_flat  output  NUM_ROADS*DATA_W  per-road averages; road r occupies bits [r*DATA_W +: DATA_W].
- avg_valid  output  1  one-cycle pulse: one road's average was just updated.
- avg_road  output  ROAD_W  road updated when avg_valid is high.
- init_done  output  1  high once window preload is complete.

Behaviour:
- States: INIT and RUN.
- Reset (reset==0 at clk edge):
  - state is INIT and the init index is 0.
  - All write pointers are 0 and every sum is INIT_VAL<<WIN_LOG2.
  - Every avg lane is INIT_VAL.
  - avg_valid, avg_road and init_done are 0; in_ready is 0.
- INIT:
  - Each cycle, writes INIT_VAL into slot [init index] of every road's buffer, then increments the index.
  - After slot 2**WIN_LOG2-1 is written, moves to RUN. INIT therefore lasts exactly 2**WIN_LOG2 cycles after reset release.
  - in_ready is 0 throughout INIT.
- RUN:
  - in_ready=1 and init_done=1 every cycle.
  - Accept occurs when in_valid & in_ready.
- Accept of road r with in_road < NUM_ROADS:
  - new_sum = sum[r] + in_data - buf[r][ptr[r]].
  - buf[r][ptr[r]] <= in_data.
  - ptr[r] <= ptr[r]+1, wrapping modulo 2**WIN_LOG2.
  - sum[r] <= new_sum.
  - avg lane r <= new_sum >> WIN_LOG2 (floor).
- Latency: the avg lane, avg_valid=1 and avg_road=r are all visible the cycle after the accept.
- Back-to-back accepts every cycle are supported, to the same or different roads.
- Non-addressed roads are unchanged.
- Sum width is DATA_W+WIN_LOG2 bits. The sum never exceeds (2**DATA_W-1)*2**WIN_LOG2, so no saturation logic is needed. The subtraction is done in sum width and cannot go negative because the oldest sample is always included in the sum.
- Out-of-range road (in_road >= NUM_ROADS) in RUN:
  - the sample is accepted (in_ready stays 1) and dropped;
  - no state change, and avg_valid stays 0 next cycle.
- avg_valid is 0 in any cycle with no valid accept in the previous cycle.
- Reset during INIT or RUN: takes full effect at the next edge with reset==0 and restarts INIT from index 0. Any in-flight avg_valid is cleared.
- in_data and in_road are sampled only on accept. They are don't-care otherwise.

Optional Feature:
- Macro: ROAD_SENSOR_PEAK_EN.
- With the macro defined:
  - adds output peak_flat, NUM_ROADS*DATA_W wide, same lane layout as avg_flat.
  - each lane holds the maximum accepted sample for that road since reset.
  - reset value of each lane is INIT_VAL.
  - the lane updates the cycle after accept when in_data > current peak.
- Without the macro: the port and its registers are absent. All other behaviour is identical.

Decomposition:
- Package road_sensor_pkg holds:
  - road index constants NORTH=0, EAST=1, SOUTH=2, WEST=3;
  - the state typedef (INIT, RUN);
  - the default INIT_VAL constant.
- Sub-module avg_channel holds one road's logic: ring buffer, write pointer, running sum, avg register and optional peak register.
- avg_channel has inputs init_we, init_idx and sample_we.
- The top instantiates NUM_ROADS avg_channel blocks and owns the FSM, init counter, handshake, road decode and avg_valid/avg_road registers.

Test Plan:
- Default parameters, reset held low then released:
  - init_done rises after exactly 64 cycles;
  - in_ready is 0 before that;
  - all four avg lanes read 20.
- Single sample to road 0:
  - 1 sample of 84 gives avg lane 0 = 21 the next cycle, with avg_valid=1 and avg_road=0;
  - lanes 1-3 stay 20.
- Fill road 0:
  - 64 consecutive samples of 84 drive lane 0 to 84;
  - a 65th sample of 0 (wrap, oldest 84 evicted) gives 82.
- Interleaved roads:
  - back-to-back accepts alternating road 1 (255) and road 3 (0) for 128 cycles;
  - lane 1 ends at 255 and lane 3 at 0;
  - avg_valid is high every cycle with the correct avg_road;
  - no sum overflow.
- Out-of-range road:
  - with NUM_ROADS=3, in_road=3 and in_data=200 is accepted;
  - avg_valid stays 0 and all lanes are unchanged.
- Reset mid-run:
  - after 10 samples to road 2, assert reset for 1 cycle;
  - all lanes return to 20, avg_valid is 0, INIT reruns for 64 cycles;
  - with ROAD_SENSOR_PEAK_EN, peak lanes return to 20.
